fir_tap_sched: RTL and testbench

Sequencing controller for the symmetric FIR datapath. It accepts one input sample per handshake and pulses the delay-line shift enable. It then steps a single shared pre-add/multiply unit through the NTAPS/2 symmetric tap pairs and drives the accumulator controls, delayed to match the datapath pipeline. Finally it presents the result with a valid/ready handshake. It sits between the sample source and the shift-register/MAC datapath; it carries no sample data itself.

---
 rtl/fir_pkg.sv | 37 +++
 rtl/fir_ctrl_pipe.sv | 48 ++++
 rtl/fir_tap_sched.sv | 176 +++++++++++++++++
 tb/tb_fir_tap_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_pkg
// Purpose  : Types and sizing shared by the symmetric FIR controller and its
//            datapath: controller state encoding, tap index type, the
//            control token carried alongside the MAC pipeline, and the tap
//            index width function.
// Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fir_state_e;

   // Index width for a filter of ntaps taps; never below one bit.
   function automatic int fir_iw(input int ntaps);
      return (ntaps <= 2) ? 1 : $clog2(ntaps);
   endfunction

   localparam int FIR_NTAPS_DEF = 8;
   localparam int FIR_IW_DEF    = fir_iw(FIR_NTAPS_DEF);

   // Tap index type for the default filter length, shared with the datapath.
   typedef logic [FIR_IW_DEF-1:0] tap_idx_t;

   // Control token travelling alongside the pre-add/multiply pipeline.
   typedef struct packed {
      logic vld;
      logic first;
   } ctrl_tok_t;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl_pipe
// Purpose  : PIPE-deep shift register for {vld, first} control tokens so the
//            accumulator controls line up with the datapath latency.
//            PIPE = 0 is a straight wire.
// Ports    : clk    in   clock, rising edge
//            rst_n  in   asynchronous active-low reset (empties the pipe)
//            tok_i  in   token issued this cycle
//            tok_o  out  token retiring this cycle
// Revision : 1.0  initial release
// ============================================================================
module fir_ctrl_pipe
   import fir_pkg::*;
#(
   parameter int PIPE = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  ctrl_tok_t tok_i,
   output ctrl_tok_t tok_o
);

   generate
      if (PIPE == 0) begin : g_bypass
         assign tok_o = tok_i;
      end else begin : g_regs
         ctrl_tok_t stage_q [PIPE];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE; i++) begin
                  stage_q[i] <= '0;
               end
            end else begin
               stage_q[0] <= tok_i;
               for (int i = 1; i < PIPE; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign tok_o = stage_q[PIPE-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_tap_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sched
// Purpose  : Sequencing controller for the symmetric FIR datapath. Accepts
//            one sample per handshake, shifts the delay line, walks the
//            NTAPS/2 symmetric tap pairs through one shared pre-add/multiply
//            unit, drives pipeline-aligned accumulator controls and presents
//            the finished result with a valid/ready handshake.
// Ports    : clk, rst_n      clock / async active-low reset
//            in_valid_i      sample available       in_ready_o   can accept
//            flush_i         clear line (IDLE only) line_clr_o   clear pulse
//            shift_en_o      delay-line shift enable
//            sel_lo_o        low tap k              sel_hi_o     tap NTAPS-1-k
//            coef_idx_o      coefficient k
//            acc_clr_o       accumulator load       acc_en_o     acc update
//            out_valid_o     result ready           out_ready_i  sink takes it
//            out_primed_o    result built from a full delay line
// Revision : 1.0  initial release
// ============================================================================
module fir_tap_sched
   import fir_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int PIPE  = 2,
   parameter int IW    = fir_iw(NTAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          flush_i,
   output logic          shift_en_o,
   output logic          line_clr_o,
   output logic [IW-1:0] sel_lo_o,
   output logic [IW-1:0] sel_hi_o,
   output logic [IW-1:0] coef_idx_o,
   output logic          acc_clr_o,
   output logic          acc_en_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic          out_primed_o
);

   localparam int M  = NTAPS / 2;
   localparam int CW = $clog2(NTAPS + 1);
   localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

   localparam logic [IW-1:0] K_LAST     = IW'(M - 1);
   localparam logic [IW-1:0] SEL_HI_TOP = IW'(NTAPS - 1);
   localparam logic [CW-1:0] FILL_MAX   = CW'(NTAPS);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE - 1);

   fir_state_e    state_q;
   logic [IW-1:0] k_q;
   logic [IW-1:0] sel_hi_q;
   logic [CW-1:0] fill_q;
   logic [DW-1:0] drain_q;
   logic          ready_q;
   logic          out_valid_q;
   logic          out_primed_q;

   logic          flush_d;
   logic          accept_d;
   ctrl_tok_t     issue_tok;
   ctrl_tok_t     retire_tok;

   // ready_q is high only while idle and is held low through reset, so the
   // handshake outputs below are all zero while rst_n is asserted. Flush
   // takes priority over a coincident sample.
   assign flush_d    = ready_q & flush_i;
   assign accept_d   = ready_q & ~flush_i & in_valid_i;

   assign in_ready_o = ready_q & ~flush_i;
   assign shift_en_o = accept_d;
   assign line_clr_o = flush_d;

   // k_q and sel_hi_q are parked at 0 outside MAC.
   assign sel_lo_o   = k_q;
   assign coef_idx_o = k_q;
   assign sel_hi_o   = sel_hi_q;

   assign out_valid_o  = out_valid_q;
   assign out_primed_o = out_primed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         sel_hi_q     <= '0;
         fill_q       <= '0;
         drain_q      <= '0;
         ready_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_primed_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush_d) begin
                  fill_q  <= '0;
                  ready_q <= 1'b1;
               end else if (accept_d) begin
                  if (fill_q != FILL_MAX) begin
                     fill_q <= fill_q + 1'b1;
                  end
                  k_q      <= '0;
                  sel_hi_q <= SEL_HI_TOP;
                  ready_q  <= 1'b0;
                  state_q  <= ST_MAC;
               end else begin
                  ready_q <= 1'b1;
               end
            end

            ST_MAC: begin
               if (k_q == K_LAST) begin
                  k_q      <= '0;
                  sel_hi_q <= '0;
                  if (PIPE == 0) begin
                     // No pipeline to drain: result is complete already.
                     out_valid_q  <= 1'b1;
                     out_primed_q <= (fill_q == FILL_MAX);
                     state_q      <= ST_HOLD;
                  end else begin
                     drain_q <= DRAIN_LOAD;
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  k_q      <= k_q + 1'b1;
                  sel_hi_q <= sel_hi_q - 1'b1;
               end
            end

            ST_DRAIN: begin
               // Leaves on the cycle the last token retires into the acc.
               if (drain_q == '0) begin
                  out_valid_q  <= 1'b1;
                  out_primed_q <= (fill_q == FILL_MAX);
                  state_q      <= ST_HOLD;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end

            ST_HOLD: begin
               if (out_ready_i) begin
                  out_valid_q  <= 1'b0;
                  out_primed_q <= 1'b0;
                  ready_q      <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign issue_tok.vld   = (state_q == ST_MAC);
   assign issue_tok.first = (k_q == '0);

   fir_ctrl_pipe #(
      .PIPE (PIPE)
   ) u_ctrl_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .tok_i (issue_tok),
      .tok_o (retire_tok)
   );

   assign acc_en_o  = retire_tok.vld;
   assign acc_clr_o = retire_tok.vld & retire_tok.first;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_sched
// Purpose  : Self-checking bench for fir_tap_sched. Drives a PIPE=2 build and
//            a PIPE=0 build; expected out_primed values are queued at sample
//            acceptance and compared when each result is handed off.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_tap_sched;

   localparam int NT = 8;
   localparam int M  = NT / 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic vin   = 1'b0;
   logic ordy  = 1'b0;
   logic fl    = 1'b0;
   logic use0  = 1'b0;

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int fill_model = 0;
   int cyc = 0;
   bit q[$];
   bit sb_exp;

   always @(posedge clk) cyc <= cyc + 1;

   // PIPE=2 instance signals
   logic       s2_ready, s2_shift, s2_lclr, s2_aclr, s2_aen, s2_ov, s2_op;
   logic [2:0] s2_sello, s2_selhi, s2_coef;
   // PIPE=0 instance signals
   logic       s0_ready, s0_shift, s0_lclr, s0_aclr, s0_aen, s0_ov, s0_op;
   logic [2:0] s0_sello, s0_selhi, s0_coef;

   fir_tap_sched #(.NTAPS(NT), .PIPE(2)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (use0 ? 1'b0 : vin),
      .in_ready_o   (s2_ready),
      .flush_i      (use0 ? 1'b0 : fl),
      .shift_en_o   (s2_shift),
      .line_clr_o   (s2_lclr),
      .sel_lo_o     (s2_sello),
      .sel_hi_o     (s2_selhi),
      .coef_idx_o   (s2_coef),
      .acc_clr_o    (s2_aclr),
      .acc_en_o     (s2_aen),
      .out_valid_o  (s2_ov),
      .out_ready_i  (use0 ? 1'b0 : ordy),
      .out_primed_o (s2_op)
   );

   fir_tap_sched #(.NTAPS(NT), .PIPE(0)) u_dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (use0 ? vin : 1'b0),
      .in_ready_o   (s0_ready),
      .flush_i      (use0 ? fl : 1'b0),
      .shift_en_o   (s0_shift),
      .line_clr_o   (s0_lclr),
      .sel_lo_o     (s0_sello),
      .sel_hi_o     (s0_selhi),
      .coef_idx_o   (s0_coef),
      .acc_clr_o    (s0_aclr),
      .acc_en_o     (s0_aen),
      .out_valid_o  (s0_ov),
      .out_ready_i  (use0 ? ordy : 1'b0),
      .out_primed_o (s0_op)
   );

   // Observed outputs of whichever instance is under test.
   logic       o_ready, o_shift, o_lclr, o_aclr, o_aen, o_ov, o_op;
   logic [2:0] o_sello, o_selhi, o_coef;
   assign o_ready = use0 ? s0_ready : s2_ready;
   assign o_shift = use0 ? s0_shift : s2_shift;
   assign o_lclr  = use0 ? s0_lclr  : s2_lclr;
   assign o_aclr  = use0 ? s0_aclr  : s2_aclr;
   assign o_aen   = use0 ? s0_aen   : s2_aen;
   assign o_ov    = use0 ? s0_ov    : s2_ov;
   assign o_op    = use0 ? s0_op    : s2_op;
   assign o_sello = use0 ? s0_sello : s2_sello;
   assign o_selhi = use0 ? s0_selhi : s2_selhi;
   assign o_coef  = use0 ? s0_coef  : s2_coef;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: compare out_primed against the queued expectation on
   // every completed output handshake.
   always @(negedge clk) begin
      if (rst_n && o_ov && ordy) begin
         if (q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            sb_exp = q.pop_front();
            check("primed", {31'd0, o_op}, {31'd0, sb_exp});
         end
      end
   end

   // One sample with full cycle checks; holds out_ready low for `hold`
   // cycles in HOLD while toggling in_valid. Starts and ends just after a
   // rising edge.
   task automatic do_sample(input int hold);
      int p;
      int to;
      logic [31:0] e;
      p  = use0 ? 0 : 2;
      to = 0;
      while (!o_ready && to < 50) begin
         @(posedge clk); #1;
         to++;
      end
      if (to >= 50) check("rdy_timeout", 0, 1);
      vin  = 1'b1;
      ordy = 1'b0;
      @(negedge clk);
      check("shift_en", {31'd0, o_shift}, 1);
      if (fill_model < NT) fill_model++;
      q.push_back(fill_model == NT);
      @(posedge clk); #1;
      vin = 1'b0;
      for (int c = 1; c <= M + p; c++) begin
         @(negedge clk);
         e = (c <= M) ? c - 1 : 0;
         check("sel_lo", {29'd0, o_sello}, e);
         check("coef",   {29'd0, o_coef},  e);
         check("sel_hi", {29'd0, o_selhi}, (c <= M) ? NT - c : 0);
         check("acc_en", {31'd0, o_aen},  {31'd0, (c >= 1 + p)});
         check("acc_clr", {31'd0, o_aclr}, {31'd0, (c == 1 + p)});
         check("ov_early", {31'd0, o_ov}, 0);
         check("rdy_busy", {31'd0, o_ready}, 0);
         @(posedge clk); #1;
      end
      for (int h = 0; h < hold; h++) begin
         vin = h[0];
         @(negedge clk);
         check("ov_hold",    {31'd0, o_ov},    1);
         check("rdy_hold",   {31'd0, o_ready}, 0);
         check("shift_hold", {31'd0, o_shift}, 0);
         check("op_hold",    {31'd0, o_op},    {31'd0, (fill_model == NT)});
         @(posedge clk); #1;
      end
      vin  = 1'b0;
      ordy = 1'b1;
      @(negedge clk);
      check("ov_hs", {31'd0, o_ov}, 1);
      @(posedge clk); #1;
      ordy = 1'b0;
      @(negedge clk);
      check("ov_drop",  {31'd0, o_ov},    0);
      check("rdy_back", {31'd0, o_ready}, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int to;
      int last;
      // Reset state
      #12;
      check("rst_outs2", {s2_ready, s2_shift, s2_lclr, s2_sello, s2_selhi, s2_coef,
                          s2_aclr, s2_aen, s2_ov, s2_op}, 0);
      check("rst_outs0", {s0_ready, s0_shift, s0_lclr, s0_sello, s0_selhi, s0_coef,
                          s0_aclr, s0_aen, s0_ov, s0_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single sample, full timing, first result not primed
      do_sample(0);

      // Reset asserted at MAC k=2
      vin = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_k",   {29'd0, o_sello}, 2);
      check("pre_rst_aen", {31'd0, o_aen},   1);
      rst_n = 1'b0;
      #1;
      check("rst_mid", {o_ready, o_shift, o_lclr, o_sello, o_selhi, o_coef,
                        o_aclr, o_aen, o_ov, o_op}, 0);
      fill_model = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_aen", {31'd0, o_aen}, 0);
         check("post_rst_ov",  {31'd0, o_ov},  0);
      end
      @(posedge clk); #1;
      do_sample(0);

      // Flush alone in IDLE
      fl = 1'b1;
      #1;
      check("flush_lclr", {31'd0, o_lclr},  1);
      check("flush_rdy",  {31'd0, o_ready}, 0);
      @(posedge clk); #1;
      fl = 1'b0;
      fill_model = 0;
      #1;
      check("flush_lclr_off", {31'd0, o_lclr}, 0);

      // Eight back-to-back samples, out_ready high
      vin  = 1'b1;
      ordy = 1'b1;
      last = 0;
      for (int i = 0; i < 8; i++) begin
         to = 0;
         @(negedge clk);
         while (!o_shift && to < 40) begin
            @(negedge clk);
            to++;
         end
         if (to >= 40) check("b2b_timeout", 0, 1);
         if (fill_model < NT) fill_model++;
         q.push_back(fill_model == NT);
         if (i > 0) check("b2b_gap", cyc - last, M + 2 + 2);
         last = cyc;
      end
      @(posedge clk); #1;
      vin = 1'b0;
      to  = 0;
      while (!o_ready && to < 50) begin
         @(posedge clk); #1;
         to++;
      end
      if (to >= 50) check("b2b_end_timeout", 0, 1);
      ordy = 1'b0;
      check("b2b_sb_drained", q.size(), 0);

      // Backpressure in HOLD, then more primed results
      do_sample(5);
      for (int i = 0; i < 5; i++) do_sample(0);

      // Flush together with in_valid: flush wins
      fl  = 1'b1;
      vin = 1'b1;
      #1;
      check("fv_lclr",  {31'd0, o_lclr},  1);
      check("fv_shift", {31'd0, o_shift}, 0);
      check("fv_rdy",   {31'd0, o_ready}, 0);
      @(posedge clk); #1;
      fl  = 1'b0;
      vin = 1'b0;
      fill_model = 0;
      #1;
      check("fv_idle", {31'd0, o_ready}, 1);
      do_sample(0);

      // PIPE=0 build
      use0 = 1'b1;
      fill_model = 0;
      @(posedge clk); #1;
      do_sample(0);

      check("sb_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
